cr_prefix_fe_ctr_bank: RTL and testbench

Parametrised feature-counter bank for the prefix engine, replacing the fixed 16×4-feature counter group. It counts per-feature byte matches across a selectable number of window slots, saturates each counter, and on end-of-data-block snapshots all counters into an output register. The snapshot is offered to the prefix builder over a valid/ready handshake, and input is back-pressured while an unaccepted snapshot is pending.

---
 rtl/cr_prefix_fe_ctr_bank.sv | 130 +++++++++++++
 tb/tb_cr_prefix_fe_ctr_bank.sv | 291 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cr_prefix_fe_ctr_bank.sv
// Feature-counter bank: per-feature byte-match counting into selectable window
// slots with saturating counters, snapshotted at end of data block and offered
// downstream over a valid/ready handshake.
module cr_prefix_fe_ctr_bank #(
    parameter int NUM_FE  = 64,
    parameter int NUM_WIN = 4,
    parameter int CTR_W   = 8,
    parameter int BYTES   = 8,
    parameter int WSEL_W  = 2
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic [NUM_FE-1:0]               fe_cfg_en,
    input  logic [NUM_FE*8-1:0]             fe_cfg_val,
    input  logic [NUM_FE*8-1:0]             fe_cfg_mask,
    input  logic                            in_valid,
    output logic                            in_ready,
    input  logic [BYTES*8-1:0]              in_char,
    input  logic [BYTES-1:0]                in_vbytes,
    input  logic [WSEL_W-1:0]               in_win_sel,
    input  logic                            in_eodb,
    output logic                            out_valid,
    input  logic                            out_ready,
    output logic [NUM_FE*NUM_WIN*CTR_W-1:0] out_ctr,
    output logic                            out_sat,
    output logic                            out_win_err
);

    localparam int INC_W = $clog2(BYTES + 1);
    // One spare bit above the wider operand so the sum never wraps before the clamp test.
    localparam int SUM_W = ((CTR_W > INC_W) ? CTR_W : INC_W) + 1;
    localparam int NCTR  = NUM_FE * NUM_WIN;
    localparam logic [SUM_W-1:0] CTR_MAX = {{(SUM_W-CTR_W){1'b0}}, {CTR_W{1'b1}}};

    logic            out_valid_reg;
    logic            out_sat_reg;
    logic            out_win_err_reg;
    logic            sat_reg;
    logic            win_err_reg;
    logic            accept;
    logic            win_ok;
    logic            blk_end;
    logic [NCTR-1:0] clamp_hit;

    // Ready depends only on whether a snapshot is still waiting to be taken.
    assign in_ready = !out_valid_reg || out_ready;
    assign accept   = in_valid && in_ready;
    assign win_ok   = ({1'b0, in_win_sel} < (WSEL_W+1)'(NUM_WIN));
    assign blk_end  = accept && in_eodb;

    assign out_valid   = out_valid_reg;
    assign out_sat     = out_sat_reg;
    assign out_win_err = out_win_err_reg;

    generate
        for (genvar gi = 0; gi < NUM_FE; gi++) begin : g_fe
            logic [BYTES-1:0] lane_hit;
            logic [INC_W-1:0] inc;

            for (genvar gj = 0; gj < BYTES; gj++) begin : g_lane
                assign lane_hit[gj] = in_vbytes[gj] && fe_cfg_en[gi] &&
                    (((in_char[gj*8 +: 8] ^ fe_cfg_val[gi*8 +: 8]) & fe_cfg_mask[gi*8 +: 8]) == 8'h00);
            end

            // Popcount of matching lanes gives this beat's increment for the feature.
            always_comb begin
                inc = '0;
                for (int k = 0; k < BYTES; k++) begin
                    inc = inc + INC_W'(lane_hit[k]);
                end
            end

            for (genvar gj = 0; gj < NUM_WIN; gj++) begin : g_win
                localparam int IDX = gi * NUM_WIN + gj;
                logic [CTR_W-1:0] live_reg;
                logic [CTR_W-1:0] snap_reg;
                logic [CTR_W-1:0] cnt_next;
                logic [SUM_W-1:0] sum;
                logic             sel;

                assign sel = accept && win_ok && (in_win_sel == WSEL_W'(gj));
                assign sum = SUM_W'(live_reg) + SUM_W'(inc);
                assign clamp_hit[IDX] = sel && (sum > CTR_MAX);
                assign cnt_next = !sel           ? live_reg :
                                  (sum > CTR_MAX) ? {CTR_W{1'b1}} : sum[CTR_W-1:0];

                // Live counter accumulates; at block end its final value moves to the snapshot.
                always_ff @(posedge clk) begin
                    if (rst) begin
                        live_reg <= '0;
                        snap_reg <= '0;
                    end else if (blk_end) begin
                        live_reg <= '0;
                        snap_reg <= cnt_next;
                    end else begin
                        live_reg <= cnt_next;
                    end
                end

                assign out_ctr[IDX*CTR_W +: CTR_W] = snap_reg;
            end
        end
    endgenerate

    // Snapshot handshake state plus sticky saturation / window-error flags for the open block.
    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid_reg   <= 1'b0;
            out_sat_reg     <= 1'b0;
            out_win_err_reg <= 1'b0;
            sat_reg         <= 1'b0;
            win_err_reg     <= 1'b0;
        end else if (blk_end) begin
            out_valid_reg   <= 1'b1;
            out_sat_reg     <= sat_reg | (|clamp_hit);
            out_win_err_reg <= win_err_reg | !win_ok;
            sat_reg         <= 1'b0;
            win_err_reg     <= 1'b0;
        end else begin
            if (out_valid_reg && out_ready) begin
                out_valid_reg <= 1'b0;
            end
            if (accept) begin
                sat_reg     <= sat_reg | (|clamp_hit);
                win_err_reg <= win_err_reg | !win_ok;
            end
        end
    end

endmodule

// File: tb/tb_cr_prefix_fe_ctr_bank.sv
// Scoreboard bench for cr_prefix_fe_ctr_bank: directed scenarios followed by
// randomized traffic, checked against a behavioural counting model.
module tb_cr_prefix_fe_ctr_bank;

    localparam int NUM_FE  = 8;
    localparam int NUM_WIN = 3;
    localparam int CTR_W   = 8;
    localparam int BYTES   = 8;
    localparam int WSEL_W  = 2;
    localparam int TOT     = NUM_FE * NUM_WIN * CTR_W;
    localparam int MAXV    = (1 << CTR_W) - 1;
    localparam logic [63:0] A8 = {8{8'h41}};

    logic                  clk = 1'b0;
    logic                  rst = 1'b1;
    logic [NUM_FE-1:0]     fe_cfg_en = '0;
    logic [NUM_FE*8-1:0]   fe_cfg_val = '0;
    logic [NUM_FE*8-1:0]   fe_cfg_mask = '0;
    logic                  in_valid = 1'b0;
    logic                  in_ready;
    logic [BYTES*8-1:0]    in_char = '0;
    logic [BYTES-1:0]      in_vbytes = '0;
    logic [WSEL_W-1:0]     in_win_sel = '0;
    logic                  in_eodb = 1'b0;
    logic                  out_valid;
    logic                  out_ready = 1'b1;
    logic [TOT-1:0]        out_ctr;
    logic                  out_sat;
    logic                  out_win_err;

    cr_prefix_fe_ctr_bank #(
        .NUM_FE(NUM_FE), .NUM_WIN(NUM_WIN), .CTR_W(CTR_W), .BYTES(BYTES), .WSEL_W(WSEL_W)
    ) dut (
        .clk(clk), .rst(rst),
        .fe_cfg_en(fe_cfg_en), .fe_cfg_val(fe_cfg_val), .fe_cfg_mask(fe_cfg_mask),
        .in_valid(in_valid), .in_ready(in_ready), .in_char(in_char),
        .in_vbytes(in_vbytes), .in_win_sel(in_win_sel), .in_eodb(in_eodb),
        .out_valid(out_valid), .out_ready(out_ready), .out_ctr(out_ctr),
        .out_sat(out_sat), .out_win_err(out_win_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [TOT-1:0] ctr;
        logic           sat;
        logic           werr;
    } snap_t;

    snap_t sb[$];
    int    checks = 0;
    int    failures = 0;
    int    live[NUM_FE][NUM_WIN];
    bit    m_sat = 0;
    bit    m_werr = 0;
    int    rdy_force = 1;   // -1 random, 0/1 forced
    bit    mon_on = 0;
    int    snap_no = 0;

    task automatic chk(input string name, input logic [TOT-1:0] got, input logic [TOT-1:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h t=%0t", name, got, exp, $time);
        end
    endtask

    function automatic void model_clear();
        for (int f = 0; f < NUM_FE; f++)
            for (int w = 0; w < NUM_WIN; w++)
                live[f][w] = 0;
        m_sat = 0;
        m_werr = 0;
    endfunction

    // Apply the beat currently on the inputs to the reference model.
    function automatic void model_beat();
        int ws;
        int n;
        int s;
        snap_t e;
        ws = int'(in_win_sel);
        if (ws >= NUM_WIN) begin
            m_werr = 1;
        end else begin
            for (int f = 0; f < NUM_FE; f++) begin
                n = 0;
                for (int k = 0; k < BYTES; k++)
                    if (in_vbytes[k] && fe_cfg_en[f] &&
                        (((in_char[8*k +: 8] ^ fe_cfg_val[8*f +: 8]) & fe_cfg_mask[8*f +: 8]) == 8'h00))
                        n++;
                s = live[f][ws] + n;
                if (s > MAXV) begin
                    s = MAXV;
                    m_sat = 1;
                end
                live[f][ws] = s;
            end
        end
        if (in_eodb) begin
            e.ctr = '0;
            for (int f = 0; f < NUM_FE; f++)
                for (int w = 0; w < NUM_WIN; w++)
                    e.ctr[(f*NUM_WIN+w)*CTR_W +: CTR_W] = CTR_W'(live[f][w]);
            e.sat = m_sat;
            e.werr = m_werr;
            sb.push_back(e);
            model_clear();
        end
    endfunction

    // out_ready driver: only this process writes out_ready.
    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (rdy_force < 0) out_ready = 1'($urandom_range(0, 1));
            else               out_ready = rdy_force[0];
        end
    end

    // Monitor: compares handshake state every cycle and the presented snapshot with the scoreboard front.
    initial begin
        forever begin
            @(negedge clk);
            if (mon_on) begin
                snap_t e;
                bit exp_v;
                exp_v = (sb.size() != 0);
                chk("out_valid", TOT'(out_valid), TOT'(exp_v));
                chk("in_ready", TOT'(in_ready), TOT'(!exp_v || out_ready));
                if (out_valid && exp_v) begin
                    e = sb[0];
                    chk("out_ctr", out_ctr, e.ctr);
                    chk("out_sat", TOT'(out_sat), TOT'(e.sat));
                    chk("out_win_err", TOT'(out_win_err), TOT'(e.werr));
                    if (out_ready) begin
                        $display("snapshot %0d consumed sat=%0d win_err=%0d ctr=%h",
                                 snap_no, out_sat, out_win_err, out_ctr);
                        snap_no++;
                        void'(sb.pop_front());
                    end
                end
            end
        end
    end

    task automatic send(input logic [63:0] ch, input logic [7:0] vb, input int ws, input bit eodb);
        int n;
        n = 0;
        @(posedge clk);
        #1;
        in_valid = 1'b1;
        in_char = ch;
        in_vbytes = vb;
        in_win_sel = WSEL_W'(ws);
        in_eodb = eodb;
        forever begin
            @(negedge clk);
            #1;
            if (in_ready) break;
            n++;
            if (n > 200) begin
                checks++;
                failures++;
                $display("FAIL send_timeout in_ready=0 required=1 t=%0t", $time);
                break;
            end
        end
        if (in_ready) model_beat();
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
            in_valid = 1'b0;
            in_eodb = 1'b0;
        end
    endtask

    task automatic do_reset();
        @(posedge clk);
        #1;
        rst = 1'b1;
        in_valid = 1'b0;
        in_eodb = 1'b0;
        @(negedge clk);
        #1;
        model_clear();
        sb.delete();
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        chk("rst_out_valid", TOT'(out_valid), '0);
        chk("rst_out_ctr", out_ctr, '0);
        chk("rst_out_sat", TOT'(out_sat), '0);
        chk("rst_out_win_err", TOT'(out_win_err), '0);
        chk("rst_in_ready", TOT'(in_ready), TOT'(1));
    endtask

    initial begin
        logic [7:0]  alpha [4];
        logic [7:0]  masks [3];
        logic [63:0] ch;
        alpha = '{8'h41, 8'h42, 8'h30, 8'h31};
        masks = '{8'hFF, 8'hF0, 8'h0F};

        model_clear();
        do_reset();
        mon_on = 1;

        // Basic count: feature 0 matches 'A', ten full beats into slot 2.
        fe_cfg_en[0] = 1'b1;
        fe_cfg_val[7:0] = 8'h41;
        fe_cfg_mask[7:0] = 8'hFF;
        for (int i = 0; i < 10; i++) send(A8, 8'hFF, 2, i == 9);

        // Masked compare on partial lanes: feature 3 upper nibble 3, lanes 0..3 valid.
        fe_cfg_en[3] = 1'b1;
        fe_cfg_val[31:24] = 8'h30;
        fe_cfg_mask[31:24] = 8'hF0;
        send(64'h3736353433323130, 8'h0F, 1, 1);

        // Saturation in slot 0, then a fresh block.
        for (int i = 0; i < 40; i++) send(A8, 8'hFF, 0, i == 39);
        send(A8, 8'hFF, 0, 1);

        // Back-pressure: snapshot held, input stalled, release restores ready at once.
        idle(1);
        rdy_force = 0;
        idle(2);
        send(A8, 8'hF0, 1, 1);
        idle(1);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            #1;
            chk("bp_in_ready", TOT'(in_ready), '0);
        end
        rdy_force = 1;
        @(posedge clk);
        #2;
        chk("bp_release_in_ready", TOT'(in_ready), TOT'(1));
        send(A8, 8'h0F, 2, 1);
        send(A8, 8'hFF, 2, 1);

        // Window error beat, then a clean block, then an empty block.
        send(A8, 8'hFF, 3, 0);
        send(A8, 8'hFF, 0, 1);
        send(A8, 8'hFF, 1, 1);
        send(64'h0, 8'h00, 0, 1);

        // Reset with a pending snapshot.
        idle(1);
        rdy_force = 0;
        idle(2);
        for (int i = 0; i < 5; i++) send(A8, 8'hFF, 1, i == 4);
        idle(1);
        do_reset();

        // Reset with partial counts, then a block counted from zero.
        rdy_force = 1;
        for (int i = 0; i < 5; i++) send(A8, 8'hFF, 2, 0);
        idle(1);
        do_reset();
        send(A8, 8'h3C, 2, 1);

        // Randomized traffic with random configuration and random consumer.
        idle(2);
        for (int f = 0; f < NUM_FE; f++) begin
            fe_cfg_en[f] = 1'($urandom_range(0, 3) != 0);
            fe_cfg_val[8*f +: 8] = alpha[$urandom_range(0, 3)];
            fe_cfg_mask[8*f +: 8] = masks[$urandom_range(0, 2)];
        end
        rdy_force = -1;
        for (int i = 0; i < 300; i++) begin
            for (int k = 0; k < BYTES; k++) ch[8*k +: 8] = alpha[$urandom_range(0, 3)];
            send(ch, 8'($urandom_range(0, 255)), $urandom_range(0, 3),
                 ($urandom_range(0, 7) == 0) || (i == 299));
        end
        idle(1);
        rdy_force = 1;
        idle(10);
        chk("drain_empty", TOT'(sb.size()), '0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
